frv_wb_arb: RTL and testbench

Writeback arbiter and register scoreboard for the frv core. Collects results from the single-cycle ALU path and the long-latency load/store path, then drives the single GPR write port (`rd_wen`/`rd_addr`/`rd_wdata`) through one registered stage. Tracks destinations of in-flight long-latency instructions so the issue stage can detect RAW hazards. Exposes the registered write as a bypass source for operand forwarding.

---
 rtl/frv_wb_arb.sv | 101 ++++++++++
 tb/tb_frv_wb_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/frv_wb_arb.sv
// Writeback arbiter and long-latency register scoreboard for the frv core.
// LSU responses win the single registered GPR write port; the ALU waits while they stream.
module frv_wb_arb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            byp_valid,
  output logic [3:0]      outstanding,
  output logic            err_unexp
);

  localparam logic [3:0] MaxOut = 4'(MAX_OUT);

  logic            wen_q, wen_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;
  logic [3:0]      out_q, out_d;
  logic            err_q, err_d;

  logic       alu_acc, accept, iss_acc, lsu_dec;
  logic [4:0] win_rd;

  always_comb begin
    alu_acc   = alu_valid && !lsu_valid;
    accept    = lsu_valid || alu_acc;
    win_rd    = lsu_valid ? lsu_rd : alu_rd;
    iss_ready = (out_q != MaxOut);
    iss_acc   = iss_valid && iss_ready;
    // A response with nothing outstanding is flagged, never allowed to underflow.
    lsu_dec   = lsu_valid && (out_q != 4'd0);

    wen_d   = accept && (win_rd != 5'd0);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = win_rd;
      wdata_d = lsu_valid ? lsu_wdata : alu_wdata;
    end

    // Clear first so that a same-cycle set of the same register wins.
    busy_d = busy_q;
    if (lsu_valid) busy_d[lsu_rd] = 1'b0;
    if (iss_acc && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    out_d = out_q;
    if (iss_acc && !lsu_dec) out_d = out_q + 4'd1;
    else if (!iss_acc && lsu_dec) out_d = out_q - 4'd1;

    err_d = err_q || (lsu_valid && (out_q == 4'd0));
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign alu_ready   = !lsu_valid;
  assign rs1_busy    = busy_q[rs1_addr];
  assign rs2_busy    = busy_q[rs2_addr];
  assign rd_wen      = wen_q;
  assign byp_valid   = wen_q;
  assign rd_addr     = addr_q;
  assign rd_wdata    = wdata_q;
  assign outstanding = out_q;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_frv_wb_arb.sv
// Directed bench for frv_wb_arb: arbitration, scoreboard, counter saturation, x0, error, reset.
module tb_frv_wb_arb;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rd_wen, byp_valid, err_unexp;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [3:0]  outstanding;

  int checks = 0;
  int failures = 0;

  frv_wb_arb #(.XLEN(32), .MAX_OUT(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .byp_valid(byp_valid),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    tick();
    tick();
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL rst_wen got %b exp 0", rd_wen); end
    checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL rst_addr got %0d exp 0", rd_addr); end
    checks++; if (rd_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got %h exp 0", rd_wdata); end
    checks++; if (byp_valid !== 1'b0) begin failures++; $display("FAIL rst_byp got %b exp 0", byp_valid); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL rst_out got %0d exp 0", outstanding); end
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL rst_err got %b exp 0", err_unexp); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rst_iss_ready got %b exp 1", iss_ready); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL rst_rs1_busy got %b exp 0", rs1_busy); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got %b exp 1", alu_ready); end
    lsu_valid = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL rst_alu_ready_lsu got %b exp 0", alu_ready); end
    lsu_valid = 1'b0;
    g_reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL alu_wen got %b exp 1", rd_wen); end
    checks++; if (byp_valid !== 1'b1) begin failures++; $display("FAIL alu_byp got %b exp 1", byp_valid); end
    checks++; if (rd_addr !== 5'd5) begin failures++; $display("FAIL alu_addr got %0d exp 5", rd_addr); end
    checks++; if (rd_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got %h exp deadbeef", rd_wdata); end
    tick();
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL alu_wen_off got %b exp 0", rd_wen); end
    checks++; if (rd_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_hold got %h exp deadbeef", rd_wdata); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd6;
    #1;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_lookahead got %b exp 0", rs1_busy); end
    tick();
    iss_valid = 1'b0;
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_set got %b exp 1", rs1_busy); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL sb_other got %b exp 0", rs2_busy); end
    checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL sb_out1 got %0d exp 1", outstanding); end
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'hCAFE0007;
    tick();
    lsu_valid = 1'b0;
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL sb_wen got %b exp 1", rd_wen); end
    checks++; if (rd_addr !== 5'd7) begin failures++; $display("FAIL sb_addr got %0d exp 7", rd_addr); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_clear got %b exp 0", rs1_busy); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL sb_out0 got %0d exp 0", outstanding); end
  endtask

  task automatic test_collision();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 32'h22;
    #1;
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL col_alu_ready got %b exp 0", alu_ready); end
    tick();
    lsu_valid = 1'b0;
    #1;
    checks++; if (rd_addr !== 5'd4) begin failures++; $display("FAIL col_lsu_addr got %0d exp 4", rd_addr); end
    checks++; if (rd_wdata !== 32'h22) begin failures++; $display("FAIL col_lsu_data got %h exp 22", rd_wdata); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL col_alu_ready2 got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL col_alu_wen got %b exp 1", rd_wen); end
    checks++; if (rd_addr !== 5'd3) begin failures++; $display("FAIL col_alu_addr got %0d exp 3", rd_addr); end
    checks++; if (rd_wdata !== 32'h11) begin failures++; $display("FAIL col_alu_data got %h exp 11", rd_wdata); end
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL col_err got %b exp 0", err_unexp); end
  endtask

  task automatic test_saturation();
    logic [4:0] rds [4];
    rds[0] = 5'd8; rds[1] = 5'd9; rds[2] = 5'd10; rds[3] = 5'd11;
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_rd = rds[i];
      tick();
    end
    iss_valid = 1'b0;
    checks++; if (outstanding !== 4'd4) begin failures++; $display("FAIL sat_out got %0d exp 4", outstanding); end
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_ready got %b exp 0", iss_ready); end
    // Full: a further issue must be refused and leave rd 13 idle.
    iss_valid = 1'b1; iss_rd = 5'd13; rs1_addr = 5'd13;
    tick();
    iss_valid = 1'b0;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sat_refused got %b exp 0", rs1_busy); end
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wdata = 32'hB;
    tick();
    checks++; if (outstanding !== 4'd3) begin failures++; $display("FAIL sat_out3 got %0d exp 3", outstanding); end
    iss_valid = 1'b1; iss_rd = 5'd12; lsu_rd = 5'd8;
    rs1_addr = 5'd12; rs2_addr = 5'd8;
    tick();
    checks++; if (outstanding !== 4'd3) begin failures++; $display("FAIL sat_both got %0d exp 3", outstanding); end
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sat_set12 got %b exp 1", rs1_busy); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL sat_clr8 got %b exp 0", rs2_busy); end
    iss_rd = 5'd9; lsu_rd = 5'd9; rs1_addr = 5'd9;
    tick();
    iss_valid = 1'b0; lsu_valid = 1'b0;
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sat_setwins got %b exp 1", rs1_busy); end
    checks++; if (outstanding !== 4'd3) begin failures++; $display("FAIL sat_out3b got %0d exp 3", outstanding); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_ready3 got %b exp 1", iss_ready); end
  endtask

  task automatic test_reset_mid();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = 32'h55;
    tick();
    lsu_valid = 1'b0;
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL mid_pre_wen got %b exp 1", rd_wen); end
    g_reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_wdata = 32'h66;
    iss_valid = 1'b1; iss_rd = 5'd13;
    tick();
    g_reset = 1'b0; alu_valid = 1'b0; iss_valid = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd12;
    #1;
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL mid_wen got %b exp 0", rd_wen); end
    checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL mid_addr got %0d exp 0", rd_addr); end
    checks++; if (rd_wdata !== 32'h0) begin failures++; $display("FAIL mid_data got %h exp 0", rd_wdata); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL mid_out got %0d exp 0", outstanding); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL mid_rs1 got %b exp 0", rs1_busy); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL mid_rs2 got %b exp 0", rs2_busy); end
    rs1_addr = 5'd13;
    #1;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL mid_ignored got %b exp 0", rs1_busy); end
  endtask

  task automatic test_x0_err();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'h99;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL x0_wen got %b exp 0", rd_wen); end
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wdata = 32'h77;
    tick();
    lsu_valid = 1'b0;
    checks++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL err_set got %b exp 1", err_unexp); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL err_out got %0d exp 0", outstanding); end
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL err_wen got %b exp 1", rd_wen); end
    checks++; if (rd_wdata !== 32'h77) begin failures++; $display("FAIL err_data got %h exp 77", rd_wdata); end
    tick();
    tick();
    checks++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", err_unexp); end
  endtask

  initial begin
    g_reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_alu();
    test_scoreboard();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_x0_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
